// File: rtl/fp_adder_pkg.sv
// Shared width constants and the generate/propagate helper for the grouped carry-lookahead adder.
package fp_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 24;
    localparam int unsigned GROUP_WIDTH   = 4;

    typedef struct packed {
        logic [GROUP_WIDTH-1:0] gen;
        logic [GROUP_WIDTH-1:0] prop;
    } gp_t;

    function automatic gp_t make_gp(input logic [GROUP_WIDTH-1:0] x,
                                    input logic [GROUP_WIDTH-1:0] y);
        gp_t r;
        r.gen  = x & y;
        r.prop = x ^ y;
        return r;
    endfunction

endpackage

// File: rtl/full_adder_cla4.sv
// Purely combinational 4-bit carry-lookahead group: sum and carry-out from two nibbles and a carry-in.
module cla4
    import fp_adder_pkg::*;
(
    input  logic [GROUP_WIDTH-1:0] x,
    input  logic [GROUP_WIDTH-1:0] y,
    input  logic                   cin,
    output logic [GROUP_WIDTH-1:0] s,
    output logic                   cout
);

    gp_t                    gp;
    logic [GROUP_WIDTH-1:0] g;
    logic [GROUP_WIDTH-1:0] p;
    logic [GROUP_WIDTH-1:0] c;

    assign gp = make_gp(x, y);
    assign g  = gp.gen;
    assign p  = gp.prop;

    // Every internal carry is flattened from g/p and cin, with no bit-to-bit ripple.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

endmodule

// File: rtl/full_adder.sv
// Registered N-bit unsigned adder built from rippling 4-bit carry-lookahead groups, one-cycle latency.
module full_adder
    import fp_adder_pkg::*;
#(
    parameter int unsigned N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         carry
);

    localparam int unsigned GROUPS = N / GROUP_WIDTH;

    logic [GROUPS:0] gc;
    logic [N-1:0]    sum_c;

    assign gc[0] = 1'b0;

    // Group carries ripple from the least significant nibble upward.
    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
        cla4 u_cla4 (
            .x    (a[gi*GROUP_WIDTH +: GROUP_WIDTH]),
            .y    (b[gi*GROUP_WIDTH +: GROUP_WIDTH]),
            .cin  (gc[gi]),
            .s    (sum_c[gi*GROUP_WIDTH +: GROUP_WIDTH]),
            .cout (gc[gi+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            sum   <= sum_c;
            carry <= gc[GROUPS];
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of the registered 24-bit carry-lookahead adder.
module tb_full_adder;

    localparam int unsigned N = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] sum;
    logic         carry;

    int checks = 0;
    int errors = 0;

    full_adder #(.N(N)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 9;
    logic [N-1:0] va [NV] = '{24'h000005, 24'h000005, 24'hFFFFFF, 24'hFFFFFF, 24'hAAAAAA,
                              24'hFFFFFF, 24'h000000, 24'h800000, 24'h123456};
    logic [N-1:0] vb [NV] = '{24'h000003, 24'h000005, 24'hFFFFFF, 24'hFFFFFF, 24'h555555,
                              24'h000001, 24'h000000, 24'h800000, 24'h654321};
    logic [N-1:0] vs [NV] = '{24'h000008, 24'h00000A, 24'hFFFFFE, 24'hFFFFFE, 24'hFFFFFF,
                              24'h000000, 24'h000000, 24'h000000, 24'h777777};
    logic         vc [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [N:0] exp_r;

        // Reset takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_eq("reset_sum", 32'(sum), 32'h0);
        check_eq("reset_carry", 32'(carry), 32'h0);

        a = 24'h000005;
        b = 24'h000003;
        step();
        check_eq("reset_hold", 32'({carry, sum}), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            a = va[i];
            b = vb[i];
            if (i > 0) begin
                #1;
                check_eq($sformatf("no_bypass_%0d", i), 32'({carry, sum}),
                         32'({vc[i-1], vs[i-1]}));
            end
            step();
            check_eq($sformatf("vec%0d_sum", i), 32'(sum), 32'(vs[i]));
            check_eq($sformatf("vec%0d_carry", i), 32'(carry), 32'(vc[i]));
        end

        a = 24'hFFFFFF;
        b = 24'hFFFFFF;
        step();
        check_eq("pre_rst_ovf", 32'({carry, sum}), 32'h1FFFFFE);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_sum", 32'(sum), 32'h0);
        check_eq("midrst_carry", 32'(carry), 32'h0);
        step();
        check_eq("midrst_hold", 32'({carry, sum}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("release_wait", 32'({carry, sum}), 32'h0);
        step();
        check_eq("post_rst_sum", 32'(sum), 32'hFFFFFE);
        check_eq("post_rst_carry", 32'(carry), 32'h1);

        // Back-to-back random pairs, one result per cycle.
        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            exp_r = {1'b0, a} + {1'b0, b};
            step();
            check_eq($sformatf("rand%0d", i), 32'({carry, sum}), 32'(exp_r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
